// File: rtl/program_loader_pkg.sv
// Shared definitions for the byte-stream program loader: defaults and FSM state codes.
package program_loader_pkg;

  localparam int unsigned MemWordsDefault = 32;
  localparam logic [7:0]  HeaderDefault   = 8'hA5;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StLen   = 3'd1;
  localparam state_t StHi    = 3'd2;
  localparam state_t StLo    = 3'd3;
  localparam state_t StWrite = 3'd4;
  localparam state_t StCsum  = 3'd5;
  localparam state_t StDone  = 3'd6;
  localparam state_t StErr   = 3'd7;

endpackage

// File: rtl/loader_checksum.sv
// 8-bit modulo-256 running sum of frame payload bytes, with synchronous clear.
module loader_checksum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       add_en_i,
  input  logic [7:0] data_i,
  output logic [7:0] sum_o
);

  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (add_en_i) begin
      sum_d = sum_q + data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/program_loader.sv
// Receives a framed byte stream, writes 16-bit instruction words into CPU memory and
// releases the CPU from reset once the frame checksum matches.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MemWordsDefault,
  parameter logic [7:0]  HEADER    = HeaderDefault
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [7:0]                   in_data,
  output logic                         in_ready,
  output logic                         mem_we,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
  output logic [15:0]                  mem_wdata,
  output logic                         cpu_run,
  output logic                         busy,
  output logic                         error
);

  localparam int unsigned AddrW = $clog2(MEM_WORDS);
  // Counter must reach MEM_WORDS itself, so it is one value wider than the address.
  localparam int unsigned CntW  = $clog2(MEM_WORDS + 1);

  state_t           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CntW-1:0]  len_q, len_d;
  logic [7:0]       hi_q, hi_d;
  logic             mem_we_q, mem_we_d;
  logic [AddrW-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]      mem_wdata_q, mem_wdata_d;
  logic             cpu_run_q, cpu_run_d;
  logic             busy_q, busy_d;
  logic             error_q, error_d;

  logic             accept;
  logic             csum_clr;
  logic             csum_add;
  logic [7:0]       csum;

  assign in_ready = (state_q != StWrite) && (state_q != StDone);
  assign accept   = in_valid && in_ready;

  loader_checksum u_checksum (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (csum_clr),
    .add_en_i (csum_add),
    .data_i   (in_data),
    .sum_o    (csum)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    hi_d        = hi_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    csum_clr    = 1'b0;
    csum_add    = 1'b0;

    case (state_q)
      StIdle, StErr: begin
        if (accept && (in_data == HEADER)) begin
          state_d  = StLen;
          cnt_d    = '0;
          csum_clr = 1'b1;
        end
      end
      StLen: begin
        if (accept) begin
          if ((in_data == 8'd0) || (32'(in_data) > MEM_WORDS)) begin
            state_d = StErr;
          end else begin
            len_d   = CntW'(in_data);
            state_d = StHi;
          end
        end
      end
      StHi: begin
        // High byte is staged so mem_wdata only changes together with the strobe.
        if (accept) begin
          hi_d     = in_data;
          csum_add = 1'b1;
          state_d  = StLo;
        end
      end
      StLo: begin
        if (accept) begin
          csum_add    = 1'b1;
          mem_wdata_d = {hi_q, in_data};
          mem_addr_d  = cnt_q[AddrW-1:0];
          mem_we_d    = 1'b1;
          state_d     = StWrite;
        end
      end
      StWrite: begin
        cnt_d   = cnt_q + CntW'(1);
        state_d = (cnt_d < len_q) ? StHi : StCsum;
      end
      StCsum: begin
        if (accept) begin
          state_d = (in_data == csum) ? StDone : StErr;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Status outputs are registered from the next state so they never glitch.
    cpu_run_d = (state_d == StDone);
    error_d   = (state_d == StErr);
    busy_d    = (state_d == StLen) || (state_d == StHi) || (state_d == StLo) ||
                (state_d == StWrite) || (state_d == StCsum);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      len_q       <= '0;
      hi_q        <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_run_q   <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      hi_q        <= hi_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_run_q   <= cpu_run_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_run   = cpu_run_q;
  assign busy      = busy_q;
  assign error     = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a frame-parsing model predicts memory writes and
// final status; a monitor checks every write strobe against the expected queue.
module tb_program_loader;

  localparam int unsigned MW  = 32;
  localparam logic [7:0]  HDR = 8'hA5;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_run;
  logic        busy;
  logic        error;

  program_loader #(
    .MEM_WORDS (MW),
    .HEADER    (HDR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_run   (cpu_run),
    .busy      (busy),
    .error     (error)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  hist[$];
  int          pushed = 0;
  int          we_count = 0;
  logic        prev_we = 1'b0;
  logic [4:0]  last_addr = '0;
  logic [15:0] last_wdata = '0;

  logic        m_done, m_err, m_busy;
  logic [31:0] m_writes[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Parse every byte accepted since the last reset as a sequence of frames.
  task automatic run_model();
    int i = 0;
    int n;
    logic [7:0] sum, hi, lo;
    m_done = 1'b0;
    m_err  = 1'b0;
    m_busy = 1'b0;
    m_writes.delete();
    while (i < hist.size() && !m_done) begin
      if (hist[i] != HDR) begin
        i++;
        continue;
      end
      i++;
      m_err  = 1'b0;
      m_busy = 1'b1;
      if (i >= hist.size()) return;
      n = int'(hist[i]);
      i++;
      if (n == 0 || n > int'(MW)) begin
        m_err  = 1'b1;
        m_busy = 1'b0;
        continue;
      end
      sum = '0;
      for (int w = 0; w < n; w++) begin
        if (i + 1 >= hist.size()) return;
        hi = hist[i];
        lo = hist[i+1];
        i += 2;
        m_writes.push_back({16'(w), hi, lo});
        sum = sum + hi + lo;
      end
      if (i >= hist.size()) return;
      if (hist[i] == sum) m_done = 1'b1;
      else m_err = 1'b1;
      m_busy = 1'b0;
      i++;
    end
  endtask

  task automatic sync_model();
    run_model();
    while (pushed < m_writes.size()) begin
      exp_q.push_back(m_writes[pushed]);
      pushed++;
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // in_valid is left high afterwards so back-to-back sends keep it asserted.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_timeout", 32'(in_ready), 32'd1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    hist.push_back(b);
    sync_model();
  endtask

  task automatic send_seq(input bq_t s, input bit gaps);
    foreach (s[k]) begin
      if (gaps && $urandom_range(3) == 0) idle($urandom_range(2, 1));
      send_byte(s[k]);
    end
  endtask

  function automatic bq_t make_frame(input int n, input bit bad);
    bq_t f;
    logic [7:0] s = '0;
    logic [7:0] b;
    f.push_back(HDR);
    f.push_back(8'(n));
    for (int k = 0; k < 2 * n; k++) begin
      b = 8'($urandom);
      f.push_back(b);
      s = s + b;
    end
    f.push_back(bad ? s + 8'd1 : s);
    return f;
  endfunction

  task automatic check_status(input string tag);
    idle(3);
    run_model();
    check({tag, "_cpu_run"}, 32'(cpu_run), 32'(m_done));
    check({tag, "_error"}, 32'(error), 32'(m_err));
    check({tag, "_busy"}, 32'(busy), 32'(m_busy));
    check({tag, "_in_ready"}, 32'(in_ready), 32'(!m_done));
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    // No clock edge has passed yet, so these prove the asynchronous path.
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_pending_writes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    hist.delete();
    pushed = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_we    <= 1'b0;
      last_addr  <= '0;
      last_wdata <= '0;
    end else begin
      if (mem_we) begin
        check("we_single_cycle", 32'(prev_we), 32'd0);
        check("ready_low_in_write", 32'(in_ready), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", {11'd0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
        end else begin
          check("write_addr_data", {11'd0, mem_addr, mem_wdata}, exp_q.pop_front());
        end
        we_count <= we_count + 1;
      end else begin
        check("addr_stable", 32'(mem_addr), 32'(last_addr));
        check("wdata_stable", 32'(mem_wdata), 32'(last_wdata));
      end
      prev_we    <= mem_we;
      last_addr  <= mem_addr;
      last_wdata <= mem_wdata;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    bq_t s;
    int  w0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    do_reset();

    // Two-word frame; payload 01+05+06+08 sums to 14.
    s = '{8'hA5, 8'h02, 8'h01, 8'h05, 8'h06, 8'h08, 8'h14};
    send_seq(s, 1'b0);
    check_status("valid2");

    // Bad checksum leaves the written word, then a clean retry from ERR.
    do_reset();
    s = '{8'hA5, 8'h01, 8'h04, 8'h00, 8'hFF};
    send_seq(s, 1'b0);
    check_status("badcsum");
    s = '{8'hA5, 8'h01, 8'h04, 8'h00, 8'h04};
    send_seq(s, 1'b0);
    check_status("retry");

    // Illegal lengths: zero and MEM_WORDS+1.
    do_reset();
    s = '{8'hA5, 8'h00};
    send_seq(s, 1'b0);
    check_status("len0");
    s = '{8'hA5, 8'h21};
    send_seq(s, 1'b0);
    check_status("len33");

    // Garbage ahead of a one-word frame.
    do_reset();
    s = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h01, 8'hAB, 8'hCD, 8'h78};
    send_seq(s, 1'b0);
    check_status("garbage");

    // in_valid held high through every WRITE stall.
    do_reset();
    w0 = we_count;
    send_seq(make_frame(4, 1'b0), 1'b0);
    check_status("backpressure");
    check("backpressure_we_pulses", 32'(we_count - w0), 32'd4);

    // Reset right after the high byte of the first word.
    do_reset();
    s = '{8'hA5, 8'h01, 8'h11};
    send_seq(s, 1'b0);
    do_reset();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_idle_ready", 32'(in_ready), 32'd1);
    send_seq(make_frame(2, 1'b0), 1'b1);
    check_status("after_midrst");

    // Full-depth frame covers addresses 0..MW-1.
    do_reset();
    w0 = we_count;
    send_seq(make_frame(int'(MW), 1'b0), 1'b1);
    check_status("maxlen");
    check("maxlen_we_pulses", 32'(we_count - w0), MW);

    for (int it = 0; it < 20; it++) begin
      do_reset();
      s.delete();
      for (int g = 0; g < int'($urandom_range(3)); g++) begin
        logic [7:0] gb;
        gb = 8'($urandom);
        if (gb == HDR) gb = 8'h00;
        s.push_back(gb);
      end
      send_seq(s, 1'b1);
      if ($urandom_range(1) == 1) begin
        send_seq(make_frame(int'($urandom_range(8, 1)), 1'b1), 1'b1);
        check_status("rand_bad");
      end
      send_seq(make_frame(int'($urandom_range(8, 1)), 1'b0), 1'b1);
      check_status("rand_good");
    end

    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
